// File: rtl/bt_tx_arbiter.sv
// -----------------------------------------------------------------------------
// bt_tx_arbiter
//
// Round-robin arbiter and sequencer that shares one Bluetooth UART transmitter
// among N_REQ byte producers. It picks a requester, latches that requester's
// byte, runs the enable/busy/done handshake with the transmitter, and then
// pulses the requester's ack.
//
// Ports
//   clk_in     in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req        in   [N_REQ]        req[i] high: requester i has a byte
//   req_data   in   [N_REQ*DATA_W] byte of requester i at [i*DATA_W +: DATA_W]
//   ack        out  [N_REQ]        one-cycle pulse: requester's byte has gone out
//   grant_id   out  [clog2(N_REQ)] index of the requester being served
//   busy       out  high from LAUNCH entry until the return to IDLE
//   tx_enable  out  start request to the transmitter (level)
//   tx_data    out  [DATA_W]       byte to the transmitter, stable while busy
//   tx_busy    in   transmitter busy
//   tx_done    in   transmitter done (pulse or level)
//   err        out  one-cycle pulse on timeout abort
//
// Build option
//   BT_ARB_TIMEOUT_EN  when defined, a transfer that exceeds TIMEOUT_CYC
//                      cycles in LAUNCH/SEND is aborted and err pulses.
//                      When undefined, there is no timer and err is tied to 0.
// -----------------------------------------------------------------------------
module bt_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         ack,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     tx_enable,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic                     err
);

    localparam int ID_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || DATA_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("bt_tx_arbiter: N_REQ must be 2..8, DATA_W and TIMEOUT_CYC at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        SEND,
        FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              tx_en_q, tx_en_d;
    logic              busy_q, busy_d;
    logic [N_REQ-1:0]  ack_q, ack_d;

`ifdef BT_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              err_q, err_d;
`endif

    // Round-robin search: first set request at rr_ptr, rr_ptr+1, ... mod N_REQ.
    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;
    logic [DATA_W-1:0] win_data;
    logic [ID_W-1:0]   next_ptr;

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        win_data = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = ID_W'((int'(rr_ptr_q) + off) % N_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // The requester just served becomes lowest priority.
    assign next_ptr = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    // Next-state and output logic.
    // NOTE: every signal written here gets its default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        tx_en_d  = tx_en_q;
        busy_d   = busy_q;
        ack_d    = '0;
`ifdef BT_ARB_TIMEOUT_EN
        timer_d  = timer_q;
        err_d    = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    data_d  = win_data;
                    grant_d = winner;
                    tx_en_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = LAUNCH;
`ifdef BT_ARB_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end

            LAUNCH: begin
                // tx_done here is ignored: a byte only counts once busy was seen.
                if (tx_busy) begin
                    tx_en_d = 1'b0;
                    state_d = SEND;
                end
            end

            SEND: begin
                // Done only qualifies once the transmitter has also dropped busy.
                if (tx_done && !tx_busy) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        ack_d[i] = (grant_q == ID_W'(i));
                    end
                    state_d = FINISH;
                end
            end

            FINISH: begin
                rr_ptr_d = next_ptr;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef BT_ARB_TIMEOUT_EN
        if (state_q == LAUNCH || state_q == SEND) begin
            timer_d = timer_q + 1'b1;
            // Abort wins over a completion in the same cycle, so ack and err
            // can never both pulse for one byte.
            if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                err_d    = 1'b1;
                ack_d    = '0;
                tx_en_d  = 1'b0;
                rr_ptr_d = next_ptr;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        end
`endif
    end

    // State register.
    // NOTE: non-blocking assignments so every register updates from the
    // same pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            tx_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= '0;
`ifdef BT_ARB_TIMEOUT_EN
            timer_q  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            tx_en_q  <= tx_en_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
`ifdef BT_ARB_TIMEOUT_EN
            timer_q  <= timer_d;
            err_q    <= err_d;
`endif
        end
    end

    assign ack       = ack_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign tx_enable = tx_en_q;
    assign tx_data   = data_q;

`ifdef BT_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
